// File: rtl/ps2_note_pkg.sv
// ----------------------------------------------------------------------------
// ps2_note_pkg
// Shared types and constants for the PS/2 note decoder.
//   - state_e    : decoder FSM states (only IDLE/BRK without PS2_NOTE_EXT_EN)
//   - SC_*       : set-2 scan-code constants used by the decoder
//   - NOTE_COUNT : number of chromatic note slots (width of notes_held)
//   - OCTAVE_*   : octave reset value and upper saturation limit
//   - is_ignored : bytes that are dropped in every state without effect
// Optional feature macro: PS2_NOTE_EXT_EN (extended prefix + octave control).
// ----------------------------------------------------------------------------
package ps2_note_pkg;

    localparam int NOTE_COUNT = 16;

    localparam logic [1:0] OCTAVE_RST = 2'd1;
    localparam logic [1:0] OCTAVE_MAX = 2'd3;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR_FF = 8'hFF;
    localparam logic [7:0] SC_ERR_00 = 8'h00;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;

`ifdef PS2_NOTE_EXT_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BRK  = 1'b1
    } state_e;
`endif

    // Keyboard housekeeping replies; they must never disturb a pending prefix.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == SC_ACK)    || (code == SC_ECHO)   ||
               (code == SC_RESEND) || (code == SC_ERR_FF) ||
               (code == SC_ERR_00);
    endfunction

endpackage

// File: rtl/ps2_scan_to_note.sv
// ----------------------------------------------------------------------------
// ps2_scan_to_note
// Combinational lookup from a set-2 scan code to a piano-row note index.
// Ports:
//   scan_code  in  8  scan-code byte
//   hit        out 1  code belongs to the piano row
//   note_idx   out 4  chromatic index 0..15 (0 when hit=0)
// ----------------------------------------------------------------------------
module ps2_scan_to_note (
    input  logic [7:0] scan_code,
    output logic       hit,
    output logic [3:0] note_idx
);

    always_comb begin
        hit      = 1'b1;
        note_idx = 4'd0;
        case (scan_code)
            8'h1C: note_idx = 4'd0;   // A
            8'h1D: note_idx = 4'd1;   // W
            8'h1B: note_idx = 4'd2;   // S
            8'h24: note_idx = 4'd3;   // E
            8'h23: note_idx = 4'd4;   // D
            8'h2B: note_idx = 4'd5;   // F
            8'h2C: note_idx = 4'd6;   // T
            8'h34: note_idx = 4'd7;   // G
            8'h35: note_idx = 4'd8;   // Y
            8'h33: note_idx = 4'd9;   // H
            8'h3C: note_idx = 4'd10;  // U
            8'h3B: note_idx = 4'd11;  // J
            8'h42: note_idx = 4'd12;  // K
            8'h44: note_idx = 4'd13;  // O
            8'h4B: note_idx = 4'd14;  // L
            8'h4D: note_idx = 4'd15;  // P
            default: begin
                hit      = 1'b0;
                note_idx = 4'd0;
            end
        endcase
    end

endmodule

// File: rtl/ps2_note_decoder.sv
// ----------------------------------------------------------------------------
// ps2_note_decoder
// Turns the PS/2 receiver byte stream into one-cycle note-on/note-off events,
// tracks held notes and (optionally) an octave register.
//
//   state    | meaning
//   ---------+---------------------------------------------------
//   IDLE     | no prefix pending; mapped code = make
//   BRK      | F0 seen; next code = break
//   EXT      | E0 seen; next code = extended make (arrows)
//   EXT_BRK  | E0 F0 seen; next code = extended break (no action)
//
// Parameters:
//   TIMEOUT_CYCLES  cycles a pending prefix survives without another byte
// Ports:
//   CLOCK_50     in  1   system clock
//   resetn       in  1   synchronous active-low reset
//   ps2_data     in  8   received scan-code byte
//   ps2_data_en  in  1   one-cycle strobe qualifying ps2_data
//   note_valid   out 1   one-cycle pulse per note event
//   note_on      out 1   1 = press, 0 = release (held until next event)
//   note_idx     out 4   note index of last event
//   notes_held   out 16  bitmap of currently held notes
//   octave       out 2   current octave 0..3
// Optional feature macro: PS2_NOTE_EXT_EN. When undefined the FSM has only
// IDLE/BRK, E0 is ignored in IDLE, keeps BRK in BRK, and octave is fixed at 1.
// ----------------------------------------------------------------------------
module ps2_note_decoder
    import ps2_note_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic [7:0]            ps2_data,
    input  logic                  ps2_data_en,
    output logic                  note_valid,
    output logic                  note_on,
    output logic [3:0]            note_idx,
    output logic [NOTE_COUNT-1:0] notes_held,
    output logic [1:0]            octave
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  note_valid_q, note_valid_d;
    logic                  note_on_q, note_on_d;
    logic [3:0]            note_idx_q, note_idx_d;
    logic [NOTE_COUNT-1:0] held_q, held_d;

    logic       map_hit;
    logic [3:0] map_idx;
    logic       byte_ok;
    logic       is_prefix;

    ps2_scan_to_note u_map (
        .scan_code (ps2_data),
        .hit       (map_hit),
        .note_idx  (map_idx)
    );

    // Ignored bytes behave as if no strobe arrived: no transition, no reload.
    assign byte_ok   = ps2_data_en && !is_ignored(ps2_data);
    assign is_prefix = (ps2_data == SC_BREAK) || (ps2_data == SC_EXT);

    // ---------------- state register ----------------
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            note_valid_q <= 1'b0;
            note_on_q    <= 1'b0;
            note_idx_q   <= 4'd0;
            held_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            note_valid_q <= note_valid_d;
            note_on_q    <= note_on_d;
            note_idx_q   <= note_idx_d;
            held_q       <= held_d;
        end
    end

    // ---------------- next-state / timeout ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (byte_ok) begin
            // A byte in the expiry cycle still belongs to the pending prefix.
            case (state_q)
                ST_IDLE: begin
                    if (ps2_data == SC_BREAK) state_d = ST_BRK;
`ifdef PS2_NOTE_EXT_EN
                    else if (ps2_data == SC_EXT) state_d = ST_EXT;
`endif
                end
                ST_BRK: begin
                    if (ps2_data == SC_BREAK) state_d = ST_BRK;
`ifdef PS2_NOTE_EXT_EN
                    else if (ps2_data == SC_EXT) state_d = ST_EXT_BRK;
`else
                    else if (ps2_data == SC_EXT) state_d = ST_BRK;
`endif
                    else state_d = ST_IDLE;
                end
`ifdef PS2_NOTE_EXT_EN
                ST_EXT: begin
                    if (ps2_data == SC_BREAK) state_d = ST_EXT_BRK;
                    else if (ps2_data == SC_EXT) state_d = ST_EXT;
                    else state_d = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    if (is_prefix) state_d = ST_EXT_BRK;
                    else state_d = ST_IDLE;
                end
`endif
                default: state_d = ST_IDLE;
            endcase
            cnt_d = (state_d != ST_IDLE) ? CNT_LOAD : '0;
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
        end
    end

    // ---------------- event / bitmap outputs ----------------
    always_comb begin
        note_valid_d = 1'b0;
        note_on_d    = note_on_q;
        note_idx_d   = note_idx_q;
        held_d       = held_q;
        if (byte_ok && state_q == ST_IDLE && ps2_data == SC_BAT) begin
            held_d = '0;
        end else if (byte_ok && state_q == ST_IDLE && !is_prefix && map_hit) begin
            // Typematic repeats of a held key produce no event.
            if (!held_q[map_idx]) begin
                held_d[map_idx] = 1'b1;
                note_valid_d    = 1'b1;
                note_on_d       = 1'b1;
                note_idx_d      = map_idx;
            end
        end else if (byte_ok && state_q == ST_BRK && !is_prefix && map_hit) begin
            if (held_q[map_idx]) begin
                held_d[map_idx] = 1'b0;
                note_valid_d    = 1'b1;
                note_on_d       = 1'b0;
                note_idx_d      = map_idx;
            end
        end
    end

`ifdef PS2_NOTE_EXT_EN
    logic [1:0] octave_q, octave_d;

    always_comb begin
        octave_d = octave_q;
        if (byte_ok && state_q == ST_EXT && !is_prefix) begin
            if (ps2_data == SC_RIGHT && octave_q != OCTAVE_MAX) octave_d = octave_q + 2'd1;
            else if (ps2_data == SC_LEFT && octave_q != 2'd0)   octave_d = octave_q - 2'd1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) octave_q <= OCTAVE_RST;
        else         octave_q <= octave_d;
    end

    assign octave = octave_q;
`else
    assign octave = OCTAVE_RST;
`endif

    assign note_valid = note_valid_q;
    assign note_on    = note_on_q;
    assign note_idx   = note_idx_q;
    assign notes_held = held_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
module tb_ps2_note_decoder;

    localparam int TO = 16;

    logic        clk;
    logic        resetn;
    logic [7:0]  ps2_data;
    logic        ps2_data_en;
    logic        note_valid;
    logic        note_on;
    logic [3:0]  note_idx;
    logic [15:0] notes_held;
    logic [1:0]  octave;

    int checks = 0;
    int errors = 0;

    // Scoreboard entries: {note_on, note_idx}
    logic [4:0] exp_q[$];
    logic [4:0] exp_e;

    ps2_note_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .ps2_data    (ps2_data),
        .ps2_data_en (ps2_data_en),
        .note_valid  (note_valid),
        .note_on     (note_on),
        .note_idx    (note_idx),
        .notes_held  (notes_held),
        .octave      (octave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish before limit");
        $fatal(1);
    end

    // Every note_valid pulse is matched against the oldest expected event.
    always @(negedge clk) begin
        if (resetn && note_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: got on=%0d idx=%0d, required no event", note_on, note_idx);
            end else begin
                exp_e = exp_q.pop_front();
                if ({note_on, note_idx} !== exp_e) begin
                    errors++;
                    $display("FAIL event: got on=%0d idx=%0d, required on=%0d idx=%0d",
                             note_on, note_idx, exp_e[4], exp_e[3:0]);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        ps2_data    = b;
        ps2_data_en = 1'b1;
        @(negedge clk);
        ps2_data_en = 1'b0;
    endtask

    task automatic push_ev(input logic on, input logic [3:0] idx);
        exp_q.push_back({on, idx});
    endtask

    task automatic test_reset;
        resetn      = 1'b0;
        ps2_data    = 8'h00;
        ps2_data_en = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (note_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0d, required 0", note_valid); end
        checks++;
        if (note_on !== 1'b0) begin errors++; $display("FAIL reset_on: got %0d, required 0", note_on); end
        checks++;
        if (note_idx !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d, required 0", note_idx); end
        checks++;
        if (notes_held !== 16'h0000) begin errors++; $display("FAIL reset_held: got %h, required 0000", notes_held); end
        checks++;
        if (octave !== 2'd1) begin errors++; $display("FAIL reset_octave: got %0d, required 1", octave); end
    endtask

    task automatic test_single_make;
        push_ev(1'b1, 4'd0);
        send_byte(8'h1C);
        checks++;
        if (notes_held !== 16'h0001) begin errors++; $display("FAIL make_held: got %h, required 0001", notes_held); end
        push_ev(1'b0, 4'd0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL make_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_typematic;
        push_ev(1'b1, 4'd0);
        for (int i = 0; i < 3; i++) send_byte(8'h1C);
        push_ev(1'b0, 4'd0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (notes_held !== 16'h0000) begin errors++; $display("FAIL typematic_held: got %h, required 0000", notes_held); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL typematic_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_chord;
        logic [7:0]  codes [3] = '{8'h1C, 8'h24, 8'h4D};
        logic [3:0]  idxs  [3] = '{4'd0, 4'd3, 4'd15};
        logic [15:0] helds [3] = '{16'h0001, 16'h0009, 16'h8009};
        for (int i = 0; i < 3; i++) begin
            push_ev(1'b1, idxs[i]);
            send_byte(codes[i]);
            checks++;
            if (notes_held !== helds[i]) begin
                errors++;
                $display("FAIL chord_held_%0d: got %h, required %h", i, notes_held, helds[i]);
            end
        end
        push_ev(1'b0, 4'd3);
        send_byte(8'hF0);
        send_byte(8'h24);
        checks++;
        if (notes_held !== 16'h8001) begin errors++; $display("FAIL chord_release_held: got %h, required 8001", notes_held); end
        checks++;
        if (note_idx !== 4'd3 || note_on !== 1'b0) begin
            errors++;
            $display("FAIL chord_release_idx: got on=%0d idx=%0d, required on=0 idx=3", note_on, note_idx);
        end
        push_ev(1'b0, 4'd0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        push_ev(1'b0, 4'd15);
        send_byte(8'hF0);
        send_byte(8'h4D);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || notes_held !== 16'h0000) begin
            errors++;
            $display("FAIL chord_drain: got %0d pending held=%h, required 0 pending held=0000", exp_q.size(), notes_held);
            exp_q.delete();
        end
    endtask

    task automatic test_timeout;
        // Hold A so a break is observable.
        push_ev(1'b1, 4'd0);
        send_byte(8'h1C);
        // Byte lands in the cycle the counter is 0: still a break.
        push_ev(1'b0, 4'd0);
        send_byte(8'hF0);
        repeat (TO - 2) @(negedge clk);
        send_byte(8'h1C);
        checks++;
        if (notes_held !== 16'h0000) begin errors++; $display("FAIL timeout_edge_held: got %h, required 0000", notes_held); end
        // One cycle later the prefix has expired: make.
        push_ev(1'b1, 4'd0);
        send_byte(8'hF0);
        repeat (TO - 1) @(negedge clk);
        send_byte(8'h1C);
        checks++;
        if (notes_held !== 16'h0001) begin errors++; $display("FAIL timeout_expired_held: got %h, required 0001", notes_held); end
        // Ignored bytes never drop the prefix.
        push_ev(1'b0, 4'd0);
        send_byte(8'hF0);
        send_byte(8'hFA);
        send_byte(8'hEE);
        send_byte(8'h1C);
        checks++;
        if (notes_held !== 16'h0000) begin errors++; $display("FAIL ignored_held: got %h, required 0000", notes_held); end
        // Plain long wait of TIMEOUT+1 cycles after F0.
        push_ev(1'b1, 4'd0);
        send_byte(8'hF0);
        repeat (TO + 1) @(negedge clk);
        send_byte(8'h1C);
        checks++;
        if (note_on !== 1'b1 || note_idx !== 4'd0) begin
            errors++;
            $display("FAIL timeout_make: got on=%0d idx=%0d, required on=1 idx=0", note_on, note_idx);
        end
        push_ev(1'b0, 4'd0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL timeout_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_octave;
        logic [1:0] exp_oct;
        for (int i = 0; i < 4; i++) begin
            send_byte(8'hE0);
            send_byte(8'h74);
`ifdef PS2_NOTE_EXT_EN
            exp_oct = (i == 0) ? 2'd2 : 2'd3;
`else
            exp_oct = 2'd1;
`endif
            checks++;
            if (octave !== exp_oct) begin errors++; $display("FAIL octave_up_%0d: got %0d, required %0d", i, octave, exp_oct); end
        end
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
`ifdef PS2_NOTE_EXT_EN
        exp_oct = 2'd2;
`else
        exp_oct = 2'd1;
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (octave !== exp_oct) begin errors++; $display("FAIL octave_down: got %0d, required %0d", octave, exp_oct); end
        checks++;
        if (notes_held !== 16'h0000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL octave_side_effect: got held=%h pending=%0d, required held=0000 pending=0", notes_held, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_bat;
        push_ev(1'b1, 4'd0);
        send_byte(8'h1C);
        push_ev(1'b1, 4'd2);
        send_byte(8'h1B);
        checks++;
        if (notes_held !== 16'h0005) begin errors++; $display("FAIL bat_pre_held: got %h, required 0005", notes_held); end
        send_byte(8'hAA);
        repeat (2) @(negedge clk);
        checks++;
        if (notes_held !== 16'h0000) begin errors++; $display("FAIL bat_held: got %h, required 0000", notes_held); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bat_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_reset_mid;
        push_ev(1'b1, 4'd2);
        send_byte(8'h1B);
        send_byte(8'hF0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (notes_held !== 16'h0000 || octave !== 2'd1) begin
            errors++;
            $display("FAIL reset_mid_state: got held=%h oct=%0d, required held=0000 oct=1", notes_held, octave);
        end
        push_ev(1'b1, 4'd0);
        send_byte(8'h1C);
        checks++;
        if (notes_held !== 16'h0001) begin errors++; $display("FAIL reset_mid_make: got %h, required 0001", notes_held); end
        push_ev(1'b0, 4'd0);
        send_byte(8'hF0);
        send_byte(8'h1C);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL reset_mid_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] burst [5] = '{8'h1C, 8'h24, 8'hF0, 8'h1C, 8'h4D};
        push_ev(1'b1, 4'd0);
        push_ev(1'b1, 4'd3);
        push_ev(1'b0, 4'd0);
        push_ev(1'b1, 4'd15);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ps2_data    = burst[i];
            ps2_data_en = 1'b1;
        end
        @(negedge clk);
        ps2_data_en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (notes_held !== 16'h8008) begin errors++; $display("FAIL b2b_held: got %h, required 8008", notes_held); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    initial begin
        test_reset;
        test_single_make;
        test_typematic;
        test_chord;
        test_timeout;
        test_octave;
        test_bat;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_note_decoder.md
# ps2_note_decoder

Downstream stage of the PS/2 keyboard front end in the digital piano. Consumes the controller's byte stream (received byte plus one-cycle strobe), tracks make/break (F0) and extended (E0) prefixes, and turns piano-row keystrokes into one-cycle note-on/note-off events. Also maintains a held-notes bitmap and an octave register for the synthesiser and VGA stages.

## Interface
- TIMEOUT_CYCLES, 2_500_000: cycles, at 50 MHz, that a pending prefix (F0/E0) survives without a following byte; the default is 50 ms.
- CLOCK_50  in  1  system clock, 50 MHz; sole clock.
- resetn  in  1  synchronous, active-low reset, sampled on rising CLOCK_50.
- ps2_data  in  8  received scan-code byte; valid only when ps2_data_en=1.
- ps2_data_en  in  1  one-cycle strobe per received byte.
- note_valid  out  1  one-cycle pulse per accepted note event.
- note_on  out  1  1 = press, 0 = release; held until next event.
- note_idx  out  4  chromatic note index 0..15; held until next event.
- notes_held  out  16  bit i = note i currently held.
- octave  out  2  current octave, 0..3.

## Operation
- Key map (set 2 codes → idx): A 1C→0, W 1D→1, S 1B→2, E 24→3, D 23→4, F 2B→5, T 2C→6, G 34→7, Y 35→8, H 33→9, U 3C→10, J 3B→11, K 42→12, O 44→13, L 4B→14, P 4D→15. All other codes are unmapped.
- FSM states: IDLE, BRK (F0 seen), EXT (E0 seen), EXT_BRK (E0 F0 seen).
- IDLE: F0→BRK; E0→EXT; mapped code→make; AA (keyboard BAT)→clear notes_held, no event; anything else ignored.
- BRK: F0→BRK; E0→EXT_BRK; any other byte→break for that code, then IDLE.
- EXT: F0→EXT_BRK; E0→EXT; other byte→extended make, then IDLE. EXT_BRK: any byte except F0/E0→extended break, then IDLE.
- Make of mapped idx: if notes_held[idx]=0, set it and emit note_valid, note_on=1, note_idx=idx. If already held (typematic repeat), no event.
- Break of mapped idx: if notes_held[idx]=1, clear it and emit note_valid, note_on=0. If not held, no event.
- Extended make E0 6B (left arrow): octave-1, saturating at 0. E0 74 (right arrow): octave+1, saturating at 3. Extended breaks and other extended codes produce no action and no note event.
- Bytes FA, EE, FE, FF, 00 are ignored in every state, with no state change and no timeout reload.
- Timeout: in any non-IDLE state a down-counter loads TIMEOUT_CYCLES-1 on entry and on every accepted byte. At 0 the FSM returns to IDLE and drops the prefix.

## Timing
- Reset values: state IDLE, note_valid 0, note_on 0, note_idx 0, notes_held 0, octave 1, timeout counter 0.
- Latency: note_valid, notes_held and octave update on the clock edge following the cycle ps2_data_en=1, i.e. 1 cycle. note_valid is high for exactly one cycle.
- Back-to-back strobes on consecutive cycles are each processed; there is no stall and no back-pressure.
- Strobe arriving in the same cycle the timeout reaches 0: the byte wins and is processed in the prefix state.
- Reset asserted mid-prefix or mid-event drops all pending state. No event is generated by reset.
- Counter width is $clog2(TIMEOUT_CYCLES). Octave arithmetic is 2-bit saturating and never wraps.

## Configuration
- PS2_NOTE_EXT_EN defined: EXT/EXT_BRK states and octave control behave as described above.
- PS2_NOTE_EXT_EN undefined:
  - E0 is treated like an ignored byte in IDLE.
  - In BRK, E0 keeps the FSM in BRK.
  - The FSM has only IDLE and BRK.
  - octave is tied to 2'd1.

## Structure
- Package ps2_note_pkg holds:
  - state enum;
  - scan-code constants (F0, E0, AA, FA, EE, FE, arrow codes);
  - note count 16;
  - octave reset value.
- Sub-module ps2_scan_to_note: combinational lookup, 8-bit code → {hit, 4-bit idx}. Instantiated once.

## Test plan
- Reset, then strobe 1C → next cycle note_valid=1, note_on=1, note_idx=0, notes_held=16'h0001.
- Bytes 1C,1C,1C (typematic repeat) then F0,1C → exactly two pulses (on idx 0, off idx 0); notes_held ends at 0.
- Press 1C, 24, 4D, then release 24 → notes_held goes 0001→0009→8009→8001; release event shows note_idx=3.
- F0 sent, then wait TIMEOUT_CYCLES+1 (bench sets TIMEOUT_CYCLES=16), then 1C → treated as make: note_on=1, idx 0.
- With PS2_NOTE_EXT_EN: E0 74 four times → octave 2,3,3,3. Then E0 6B, E0 F0 6B → octave 2 with no note_valid. Without the macro: same bytes leave octave=1.
- Hold 1C and 1B, send AA → notes_held=0 with no pulse. Assert resetn=0 between F0 and 1C → after release, 1C produces a make.
